chip8_scanout: RTL and testbench

//   Reads the 64x32 monochrome CHIP-8 framebuffer and streams it out pixel by

---
 rtl/chip8_scanout.sv | 120 ++++++++++++
 tb/tb_chip8_scanout.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/chip8_scanout.sv
// Streams the 64x32 CHIP-8 framebuffer in raster order over valid/ready.
// The frame is latched into a shadow copy at start so mid-frame draws cannot tear it.
module chip8_scanout #(
  parameter int SCALE = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [2047:0] display_in,
  input  logic          pix_ready,
  output logic          pix_valid,
  output logic          pix_data,
  output logic          pix_sof,
  output logic          pix_eol,
  output logic          pix_last,
  output logic [5:0]    pix_x,
  output logic [4:0]    pix_y,
  output logic          busy,
  output logic          frame_done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;
  localparam logic [2:0] SMAX     = 3'(SCALE - 1);

  logic [1:0]    state;
  logic [2047:0] shadow;
  logic [5:0]    px;
  logic [4:0]    py;
  logic [2:0]    sx;
  logic [2:0]    sy;
  logic          vld_p0;
  logic          busy_q;
  logic          done_q;

  logic xfer;
  logic end_x;
  logic end_line;
  logic last_beat;

  assign xfer      = vld_p0 && pix_ready;
  assign end_x     = (sx == SMAX);
  assign end_line  = end_x && (px == 6'd63);
  assign last_beat = end_line && (sy == SMAX) && (py == 5'd31);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      shadow <= '0;
      px     <= '0;
      py     <= '0;
      sx     <= '0;
      sy     <= '0;
      vld_p0 <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            shadow <= display_in;
            px     <= '0;
            py     <= '0;
            sx     <= '0;
            sy     <= '0;
            vld_p0 <= 1'b1;
            busy_q <= 1'b1;
            state  <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (xfer) begin
            // Counters ripple sx -> px -> sy -> py; the last beat wraps all to zero.
            if (end_x) begin
              sx <= '0;
              if (px == 6'd63) begin
                px <= '0;
                if (sy == SMAX) begin
                  sy <= '0;
                  py <= py + 5'd1;
                end else begin
                  sy <= sy + 3'd1;
                end
              end else begin
                px <= px + 6'd1;
              end
            end else begin
              sx <= sx + 3'd1;
            end
            if (last_beat) begin
              vld_p0 <= 1'b0;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Flags are qualified by valid so the idle/reset counter value of zero never looks like sof.
  assign pix_valid  = vld_p0;
  assign pix_data   = vld_p0 & shadow[{py, px}];
  assign pix_sof    = vld_p0 && (px == 6'd0) && (py == 5'd0) && (sx == 3'd0) && (sy == 3'd0);
  assign pix_eol    = vld_p0 && end_line;
  assign pix_last   = vld_p0 && last_beat;
  assign pix_x      = px;
  assign pix_y      = py;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_chip8_scanout.sv
// Directed bench for chip8_scanout with SCALE=1 and SCALE=2 instances.
module tb_chip8_scanout;

  logic          clk;
  logic          reset;
  logic          start1, start2;
  logic [2047:0] disp;
  logic          rdy;

  logic       v1, d1, sof1, eol1, last1, busy1, fd1;
  logic [5:0] x1;
  logic [4:0] y1;
  logic       v2, d2, sof2, eol2, last2, busy2, fd2;
  logic [5:0] x2;
  logic [4:0] y2;

  int sel;
  logic       cv, cd, csof, ceol, clast, cbusy, cfd;
  logic [5:0] cx;
  logic [4:0] cy;

  int n_chk;
  int n_bad;

  chip8_scanout #(.SCALE(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .display_in(disp), .pix_ready(rdy),
    .pix_valid(v1), .pix_data(d1), .pix_sof(sof1), .pix_eol(eol1), .pix_last(last1),
    .pix_x(x1), .pix_y(y1), .busy(busy1), .frame_done(fd1)
  );

  chip8_scanout #(.SCALE(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .display_in(disp), .pix_ready(rdy),
    .pix_valid(v2), .pix_data(d2), .pix_sof(sof2), .pix_eol(eol2), .pix_last(last2),
    .pix_x(x2), .pix_y(y2), .busy(busy2), .frame_done(fd2)
  );

  always_comb begin
    cv = v1; cd = d1; csof = sof1; ceol = eol1; clast = last1;
    cx = x1; cy = y1; cbusy = busy1; cfd = fd1;
    if (sel == 1) begin
      cv = v2; cd = d2; csof = sof2; ceol = eol2; clast = last2;
      cx = x2; cy = y2; cbusy = busy2; cfd = fd2;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Streams one frame from the selected instance and compares every beat
  // against a raster model computed from the beat index.
  task automatic run_frame(input int sel_i, input logic [2047:0] img, input logic flip,
                           input int stall_at, input logic poke, input string tag);
    int s, total, w, b, guard, col, row, ex, ey, ones, eols;
    int e_data, e_sof, e_eol, e_last, e_xy, e_vld;
    logic ed;
    s = (sel_i == 1) ? 2 : 1;
    total = 2048 * s * s;
    w = 64 * s;
    b = 0; guard = 0; ones = 0; eols = 0;
    e_data = 0; e_sof = 0; e_eol = 0; e_last = 0; e_xy = 0; e_vld = 0;
    sel = sel_i;
    disp = img;
    rdy = 1'b1;
    if (sel_i == 1) start2 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
    if (flip) disp = ~img;
    chk({tag, "_busy"}, 32'(cbusy), 32'd1);
    while (b < total && guard < total + 200) begin
      guard++;
      start1 = 1'b0;
      col = b % w;
      row = b / w;
      ex = col / s;
      ey = row / s;
      ed = img[ey * 64 + ex];
      if (b == stall_at) begin
        rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
          chk({tag, "_stall_valid"}, 32'(cv), 32'd1);
          chk({tag, "_stall_x"}, 32'(cx), 32'(ex));
          chk({tag, "_stall_y"}, 32'(cy), 32'(ey));
          chk({tag, "_stall_data"}, 32'(cd), 32'(ed));
          @(negedge clk);
        end
        rdy = 1'b1;
      end
      if (poke && b == 10 && sel_i == 0) start1 = 1'b1;
      if (cv) begin
        if (cd !== ed) e_data++;
        if (csof !== (b == 0)) e_sof++;
        if (ceol !== (col == w - 1)) e_eol++;
        if (clast !== (b == total - 1)) e_last++;
        if (cx !== 6'(ex) || cy !== 5'(ey)) e_xy++;
        if (cd === 1'b1) ones++;
        if (ceol === 1'b1) eols++;
        b++;
      end else begin
        e_vld++;
      end
      @(negedge clk);
    end
    start1 = 1'b0;
    chk({tag, "_beats"}, 32'(b), 32'(total));
    chk({tag, "_data_errs"}, 32'(e_data), 32'd0);
    chk({tag, "_sof_errs"}, 32'(e_sof), 32'd0);
    chk({tag, "_eol_errs"}, 32'(e_eol), 32'd0);
    chk({tag, "_last_errs"}, 32'(e_last), 32'd0);
    chk({tag, "_xy_errs"}, 32'(e_xy), 32'd0);
    chk({tag, "_valid_gaps"}, 32'(e_vld), 32'd0);
    chk({tag, "_eol_count"}, 32'(eols), 32'(32 * s));
    chk({tag, "_ones"}, 32'(ones), 32'($countones(img)) * 32'(s * s));
    chk({tag, "_done_pulse"}, 32'(cfd), 32'd1);
    chk({tag, "_valid_after"}, 32'(cv), 32'd0);
    chk({tag, "_busy_after"}, 32'(cbusy), 32'd0);
    @(negedge clk);
    chk({tag, "_done_clear"}, 32'(cfd), 32'd0);
    chk({tag, "_idle_valid"}, 32'(cv), 32'd0);
  endtask

  logic [2047:0] img;

  initial begin
    n_chk = 0;
    n_bad = 0;
    sel = 0;
    reset = 1'b0;
    start1 = 1'b1;
    start2 = 1'b1;
    disp = '1;
    rdy = 1'b1;

    // Reset held with start asserted
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(v1), 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done", 32'(fd1), 32'd0);
    chk("rst_sof", 32'(sof1), 32'd0);
    chk("rst_valid2", 32'(v2), 32'd0);
    start1 = 1'b0;
    start2 = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_valid", 32'(v1), 32'd0);
    chk("post_rst_busy", 32'(busy1), 32'd0);

    // Corner pixels only, with a 5-cycle stall at beat 100 (x=36, y=1)
    img = '0;
    img[0] = 1'b1;
    img[2047] = 1'b1;
    run_frame(0, img, 1'b0, 100, 1'b0, "t2");

    // Snapshot isolation: flip the framebuffer right after acceptance
    for (int i = 0; i < 2048; i++) img[i] = ((i * 7) % 5 == 0);
    run_frame(0, img, 1'b1, -1, 1'b0, "t4a");
    run_frame(0, ~img, 1'b0, -1, 1'b0, "t4b");

    // SCALE=2 with pixel (1,0) lit
    img = '0;
    img[1] = 1'b1;
    run_frame(1, img, 1'b0, -1, 1'b0, "t5");

    // start pulsed mid-stream must not extend or restart the frame
    for (int i = 0; i < 2048; i++) img[i] = (i % 3 == 1);
    run_frame(0, img, 1'b0, -1, 1'b1, "t6s");
    repeat (3) @(negedge clk);
    chk("t6s_no_restart", 32'(v1), 32'd0);

    // Asynchronous reset in the middle of a frame
    sel = 0;
    disp = img;
    rdy = 1'b1;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (500) @(negedge clk);
    chk("t6r_mid_valid", 32'(v1), 32'd1);
    chk("t6r_mid_x", 32'(x1), 32'd52);
    chk("t6r_mid_y", 32'(y1), 32'd7);
    #1 reset = 1'b0;
    #1;
    chk("t6r_valid", 32'(v1), 32'd0);
    chk("t6r_busy", 32'(busy1), 32'd0);
    chk("t6r_x", 32'(x1), 32'd0);
    chk("t6r_y", 32'(y1), 32'd0);
    @(negedge clk);
    chk("t6r_done_in_rst", 32'(fd1), 32'd0);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t6r_done_after", 32'(fd1), 32'd0);
      chk("t6r_valid_after", 32'(v1), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
